ascii_cmd_receiver: RTL and testbench
=====================================

# ascii_cmd_receiver

Receive-side counterpart to the UART ASCII status senders. Consumes bytes from the UART RX core, assembles them into newline-terminated lines, and decodes a fixed ASCII command set: RUN, CLR, MODE, GET and SET HH:MM:SS. Each recognised command produces a single-cycle control pulse for the watch/stopwatch control logic, or a validated time-load strobe. Sits between uart_rx and the mode/time control FSMs.

## Interface
- MAX_LEN, 12: line buffer depth in characters, excluding terminator. Must be at least 12.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_valid  in  1  single-cycle strobe; rx_data is valid
- rx_data  in  8  received byte
- cmd_run  out  1  pulse: "RUN" decoded
- cmd_clr  out  1  pulse: "CLR" decoded
- cmd_mode  out  1  pulse: "MODE" decoded
- cmd_get  out  1  pulse: "GET" decoded (triggers an ascii sender)
- set_valid  out  1  pulse: "SET" decoded and in range
- set_hour  out  5  loaded hour, binary 0–23
- set_min  out  6  loaded minute, binary 0–59
- set_sec  out  6  loaded second, binary 0–59
- cmd_err  out  1  pulse: non-empty line not recognised, or overflow
- busy  out  1  high in PARSE and EMIT states

## Operation
- **States.** COLLECT → PARSE → EMIT → COLLECT.
- **COLLECT, on rx_valid:**
  - 0x0D ('\r') is ignored.
  - 'a'–'z' are folded to uppercase before storage.
  - 0x0A ('\n') ends the line.
    - Length 0: no action, stay in COLLECT.
    - Otherwise: go to PARSE.
  - Any other byte is stored at buf[len] if len < MAX_LEN, then len increments.
  - If len == MAX_LEN when a byte arrives, the byte is discarded and the sticky overflow flag is set.
- **PARSE (1 cycle).** Compare the buffer and len against the patterns and register the decode result. The overflow flag forces an error result.
  - "RUN" (len 3) → run
  - "CLR" (len 3) → clr
  - "MODE" (len 4) → mode
  - "GET" (len 3) → get
  - "SET HH:MM:SS" (len 12): exact positions; space at index 3, ':' at 6 and 9, digits '0'–'9' at 4,5,7,8,10,11.
    - Value = 10·tens + units.
    - Range: hour ≤ 23, min ≤ 59, sec ≤ 59.
    - Any violation → error.
  - Anything else → error.
- **EMIT (1 cycle).** Assert exactly one of cmd_run, cmd_clr, cmd_mode, cmd_get, set_valid or cmd_err. Clear len and overflow. Return to COLLECT.
- **Time registers.** set_hour, set_min and set_sec update only in the EMIT cycle of a valid SET, together with set_valid. They hold their value otherwise, including across errors.
- **rx_valid while busy.** The byte is discarded and the next line starts empty. The byte is not counted toward overflow.
- **Data width.** Buffer entries are 8 bits. Digit conversion is rx_data − 0x30 on 4 bits. The multiply by 10 is implemented as (x<<3)+(x<<1).

## Timing
- **Reset values.** State COLLECT, len 0, overflow 0. All outputs are 0, including set_hour, set_min and set_sec.
- **Latency.** '\n' accepted at cycle N → PARSE at N+1 → command pulse high during cycle N+2 only, with busy high during N+1 and N+2. COLLECT resumes at N+3.
- **Pulse width.** Every command pulse is exactly 1 cycle and mutually exclusive with the others.
- **Back-to-back bytes.** Accepted on consecutive cycles while in COLLECT.
- **rst mid-line.** Partially collected characters are lost. Bytes after reset form a new line.
- **rst during PARSE/EMIT.** The pending pulse is suppressed.
- **Wrap/overflow.** Writes stop at MAX_LEN; no wrap. The error is reported on the terminating '\n', not at overflow time.

## Test plan
- **RUN command.** Send "RUN\n" with 10-cycle byte gaps → cmd_run high exactly one cycle, 2 cycles after '\n'. All other pulses stay 0 and busy is high for 2 cycles.
- **SET, lowercase with CR.** Send "set 12:34:56\r\n" → set_valid pulse with set_hour=12, set_min=34, set_sec=56. Values hold afterwards.
- **SET out of range.** Send "SET 24:00:00\n", then "SET 23:60:00\n" → two cmd_err pulses. set_hour, set_min and set_sec remain 12/34/56 from the prior test.
- **Overflow, then recovery.** Send "ABCDEFGHIJKLMN\n" (14 chars) → single cmd_err. Then "CLR\n" → cmd_clr. Then "\n" alone → no pulse.
- **Discard while busy.** Send "GET\n" followed by 'M' on the very next cycle (during PARSE) → cmd_get pulse. 'M' is dropped; then "ODE\n" → cmd_err.
- **Reset mid-line.** Send "RU", assert rst for 2 cycles, then send "N\n" → cmd_err only; no cmd_run. All outputs read 0 during reset.

Source files
------------

// File: rtl/ascii_cmd_receiver.sv
// ascii_cmd_receiver: assembles UART RX bytes into lines and decodes
// RUN / CLR / MODE / GET / SET HH:MM:SS into single-cycle control pulses.
module ascii_cmd_receiver #(
    parameter int MAX_LEN = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       cmd_run,
    output logic       cmd_clr,
    output logic       cmd_mode,
    output logic       cmd_get,
    output logic       set_valid,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       cmd_err,
    output logic       busy
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(MAX_LEN);

    typedef enum logic [1:0] {COLLECT, PARSE, EMIT} state_t;
    typedef enum logic [2:0] {R_ERR, R_RUN, R_CLR, R_MODE, R_GET, R_SET} res_t;

    state_t      state;
    logic [LW-1:0] len_q;
    logic        ovf_q;
    logic [7:0]  line_buf [MAX_LEN];

    logic        is_cr;
    logic        is_lf;
    logic        has_room;
    logic        store;
    logic [7:0]  folded;
    logic [6:0]  hv;
    logic [6:0]  mv;
    logic [6:0]  sv;
    logic        set_ok;
    res_t        res;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= "0") && (c <= "9");
    endfunction

    function automatic logic [6:0] two_digit(input logic [7:0] t,
                                             input logic [7:0] u);
        logic [3:0] a;
        logic [3:0] b;
        logic [6:0] a7;
        a  = 4'(t - 8'h30);
        b  = 4'(u - 8'h30);
        a7 = {3'b000, a};
        return (a7 << 3) + (a7 << 1) + {3'b000, b};
    endfunction

    assign is_cr    = (rx_data == 8'h0D);
    assign is_lf    = (rx_data == 8'h0A);
    assign has_room = (len_q < LW'(MAX_LEN));
    assign store    = (state == COLLECT) && rx_valid && !is_cr && !is_lf
                      && has_room;
    assign folded   = ((rx_data >= "a") && (rx_data <= "z"))
                      ? (rx_data - 8'h20) : rx_data;

    assign hv = two_digit(line_buf[4], line_buf[5]);
    assign mv = two_digit(line_buf[7], line_buf[8]);
    assign sv = two_digit(line_buf[10], line_buf[11]);

    // Pattern match of the collected line against the command set
    always_comb begin
        set_ok = (len_q == LW'(12))
                 && (line_buf[0] == "S") && (line_buf[1] == "E")
                 && (line_buf[2] == "T") && (line_buf[3] == " ")
                 && (line_buf[6] == ":") && (line_buf[9] == ":")
                 && is_digit(line_buf[4]) && is_digit(line_buf[5])
                 && is_digit(line_buf[7]) && is_digit(line_buf[8])
                 && is_digit(line_buf[10]) && is_digit(line_buf[11])
                 && (hv <= 7'd23) && (mv <= 7'd59) && (sv <= 7'd59);
        res = R_ERR;
        if (ovf_q) begin
            res = R_ERR;
        end else if (len_q == LW'(3) && line_buf[0] == "R"
                     && line_buf[1] == "U" && line_buf[2] == "N") begin
            res = R_RUN;
        end else if (len_q == LW'(3) && line_buf[0] == "C"
                     && line_buf[1] == "L" && line_buf[2] == "R") begin
            res = R_CLR;
        end else if (len_q == LW'(4) && line_buf[0] == "M"
                     && line_buf[1] == "O" && line_buf[2] == "D"
                     && line_buf[3] == "E") begin
            res = R_MODE;
        end else if (len_q == LW'(3) && line_buf[0] == "G"
                     && line_buf[1] == "E" && line_buf[2] == "T") begin
            res = R_GET;
        end else if (set_ok) begin
            res = R_SET;
        end
    end

    // Line buffer write; contents beyond len are never looked at
    always_ff @(posedge clk) begin
        if (store) begin
            line_buf[len_q[IW-1:0]] <= folded;
        end
    end

    // Line collection, decode and single-cycle pulse emission
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            busy      <= 1'b0;
            cmd_run   <= 1'b0;
            cmd_clr   <= 1'b0;
            cmd_mode  <= 1'b0;
            cmd_get   <= 1'b0;
            set_valid <= 1'b0;
            cmd_err   <= 1'b0;
            set_hour  <= '0;
            set_min   <= '0;
            set_sec   <= '0;
        end else begin
            cmd_run   <= 1'b0;
            cmd_clr   <= 1'b0;
            cmd_mode  <= 1'b0;
            cmd_get   <= 1'b0;
            set_valid <= 1'b0;
            cmd_err   <= 1'b0;
            unique case (state)
                COLLECT: begin
                    if (rx_valid) begin
                        if (is_lf) begin
                            if (len_q != '0) begin
                                state <= PARSE;
                                busy  <= 1'b1;
                            end
                        end else if (!is_cr) begin
                            if (has_room) begin
                                len_q <= len_q + LW'(1);
                            end else begin
                                ovf_q <= 1'b1;
                            end
                        end
                    end
                end
                PARSE: begin
                    state <= EMIT;
                    unique case (res)
                        R_RUN:  cmd_run  <= 1'b1;
                        R_CLR:  cmd_clr  <= 1'b1;
                        R_MODE: cmd_mode <= 1'b1;
                        R_GET:  cmd_get  <= 1'b1;
                        R_SET: begin
                            set_valid <= 1'b1;
                            set_hour  <= hv[4:0];
                            set_min   <= mv[5:0];
                            set_sec   <= sv[5:0];
                        end
                        default: cmd_err <= 1'b1;
                    endcase
                end
                EMIT: begin
                    state <= COLLECT;
                    busy  <= 1'b0;
                    len_q <= '0;
                    ovf_q <= 1'b0;
                end
                default: begin
                    state <= COLLECT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_cmd_receiver.sv
// tb_ascii_cmd_receiver: directed and random line stimulus, compared
// every cycle against a line-level behavioural model.
module tb_ascii_cmd_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       cmd_run, cmd_clr, cmd_mode, cmd_get, set_valid, cmd_err, busy;
    logic [4:0] set_hour;
    logic [5:0] set_min, set_sec;

    ascii_cmd_receiver #(.MAX_LEN(12)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .cmd_run(cmd_run), .cmd_clr(cmd_clr), .cmd_mode(cmd_mode),
        .cmd_get(cmd_get), .set_valid(set_valid), .set_hour(set_hour),
        .set_min(set_min), .set_sec(set_sec), .cmd_err(cmd_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    // model: 0 collecting, 1 parsing, 2 emitting
    int         phase = 0;
    logic [7:0] mq[$];
    bit         ovf = 0;
    int         pend = 0;   // 0 err 1 run 2 clr 3 mode 4 get 5 set
    int         ph = 0, pm = 0, ps = 0;
    int         eh = 0, em = 0, es = 0;

    int cnt[6];
    int cnt_busy = 0;
    int snap[6];
    int snap_busy = 0;
    logic [7:0] tx_q[$];

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit eq(string p);
        if (mq.size() != p.len()) return 0;
        for (int i = 0; i < p.len(); i++)
            if (mq[i] != p[i]) return 0;
        return 1;
    endfunction

    function automatic bit dig(int i);
        return mq[i] >= 8'h30 && mq[i] <= 8'h39;
    endfunction

    function automatic int val(int i);
        return (int'(mq[i]) - 48) * 10 + (int'(mq[i + 1]) - 48);
    endfunction

    task automatic decode();
        pend = 0;
        if (ovf) pend = 0;
        else if (eq("RUN")) pend = 1;
        else if (eq("CLR")) pend = 2;
        else if (eq("MODE")) pend = 3;
        else if (eq("GET")) pend = 4;
        else if (mq.size() == 12 && mq[0] == 8'h53 && mq[1] == 8'h45
                 && mq[2] == 8'h54 && mq[3] == 8'h20 && mq[6] == 8'h3A
                 && mq[9] == 8'h3A && dig(4) && dig(5) && dig(7)
                 && dig(8) && dig(10) && dig(11)) begin
            ph = val(4);
            pm = val(7);
            ps = val(10);
            if (ph <= 23 && pm <= 59 && ps <= 59) pend = 5;
        end
    endtask

    // behavioural model advanced on each clock edge
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            phase = 0; mq.delete(); ovf = 0; pend = 0;
            eh = 0; em = 0; es = 0;
        end else if (phase == 1) begin
            phase = 2;
            if (pend == 5) begin eh = ph; em = pm; es = ps; end
        end else if (phase == 2) begin
            phase = 0; mq.delete(); ovf = 0;
        end else if (rx_valid) begin
            if (rx_data == 8'h0A) begin
                if (mq.size() > 0) begin decode(); phase = 1; end
            end else if (rx_data != 8'h0D) begin
                if (mq.size() < 12)
                    mq.push_back((rx_data >= 8'h61 && rx_data <= 8'h7A)
                                 ? rx_data - 8'h20 : rx_data);
                else
                    ovf = 1;
            end
        end
    end

    // per-cycle comparison of every output
    always @(negedge clk) begin
        logic [5:0] ep, ap;
        logic [23:0] ev, av;
        if (chk_en) begin
            ep = 6'b0;
            if (phase == 2) ep = 6'b000001 << (pend == 0 ? 0 : 6 - pend);
            ap = {cmd_run, cmd_clr, cmd_mode, cmd_get, set_valid, cmd_err};
            ev = {(phase != 0), ep, 5'(eh), 6'(em), 6'(es)};
            av = {busy, ap, set_hour, set_min, set_sec};
            n_cmp++;
            if (av !== ev) begin
                n_bad++;
                $display("FAIL cycle t=%0t: got %h expected %h", $time, av, ev);
            end
            for (int i = 0; i < 6; i++) if (ap[5 - i]) cnt[i]++;
            if (busy) cnt_busy++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk); #1;
        rx_valid = 1'b0;
        repeat (gap) begin @(negedge clk); #1; end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
    endtask

    task automatic send_line(input string s, input int gap);
        send_str(s, gap);
        send_byte(8'h0A, gap);
    endtask

    task automatic take_snap();
        for (int i = 0; i < 6; i++) snap[i] = cnt[i];
        snap_busy = cnt_busy;
    endtask

    task automatic chk_delta(string name, int r, int c, int m, int g,
                             int s, int e);
        int a, x;
        a = 0; x = 0;
        for (int i = 0; i < 6; i++) a = a * 10 + (cnt[i] - snap[i]);
        x = ((((r * 10 + c) * 10 + m) * 10 + g) * 10 + s) * 10 + e;
        check(name, a, x);
    endtask

    function automatic logic [7:0] rcase(input logic [7:0] c);
        if (c >= 8'h41 && c <= 8'h5A && $urandom_range(0, 1) == 1)
            return c | 8'h20;
        return c;
    endfunction

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) tx_q.push_back(rcase(s[i]));
    endtask

    task automatic push_num(input int tens, input int units);
        tx_q.push_back(8'(8'h30 + tens));
        tx_q.push_back(8'(8'h30 + units));
    endtask

    task automatic random_line();
        int k;
        tx_q.delete();
        k = $urandom_range(0, 5);
        case (k)
            0: begin
                case ($urandom_range(0, 3))
                    0: push_str("RUN");
                    1: push_str("CLR");
                    2: push_str("MODE");
                    default: push_str("GET");
                endcase
            end
            1, 2: begin
                push_str("SET ");
                push_num($urandom_range(0, 2), $urandom_range(0, 9));
                tx_q.push_back(8'h3A);
                push_num($urandom_range(0, 6), $urandom_range(0, 9));
                tx_q.push_back(8'h3A);
                push_num($urandom_range(0, 6), $urandom_range(0, 9));
                if (k == 2 && $urandom_range(0, 2) == 0)
                    tx_q[$urandom_range(0, 11)] = 8'($urandom_range(32, 126));
            end
            3: begin
                repeat ($urandom_range(1, 16))
                    tx_q.push_back(8'($urandom_range(32, 126)));
            end
            default: ;
        endcase
        if ($urandom_range(0, 4) == 0) tx_q.push_back(8'h0D);
        tx_q.push_back(8'h0A);
        foreach (tx_q[i]) send_byte(tx_q[i], $urandom_range(0, 2));
    endtask

    initial begin
        for (int i = 0; i < 6; i++) cnt[i] = 0;
        @(posedge clk);
        chk_en = 1;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_hour", set_hour, 0);
        check("rst_sec", set_sec, 0);
        #1 rst = 1'b0;
        idle(2);

        take_snap();
        send_line("RUN", 10);
        chk_delta("run_pulse", 1, 0, 0, 0, 0, 0);
        check("run_busy", cnt_busy - snap_busy, 2);

        take_snap();
        send_str("set 12:34:56", 0);
        send_byte(8'h0D, 0);
        send_byte(8'h0A, 0);
        idle(6);
        chk_delta("set_pulse", 0, 0, 0, 0, 1, 0);
        check("set_hour", set_hour, 12);
        check("set_min", set_min, 34);
        check("set_sec", set_sec, 56);

        take_snap();
        send_line("SET 24:00:00", 0);
        idle(4);
        send_line("SET 23:60:00", 0);
        idle(4);
        chk_delta("set_range", 0, 0, 0, 0, 0, 2);
        check("hold_hour", set_hour, 12);
        check("hold_min", set_min, 34);
        check("hold_sec", set_sec, 56);

        take_snap();
        send_line("ABCDEFGHIJKLMN", 0);
        idle(4);
        chk_delta("overflow", 0, 0, 0, 0, 0, 1);
        take_snap();
        send_line("CLR", 0);
        idle(4);
        chk_delta("clr_after", 0, 1, 0, 0, 0, 0);
        take_snap();
        send_byte(8'h0A, 0);
        idle(4);
        chk_delta("empty_line", 0, 0, 0, 0, 0, 0);
        check("empty_busy", cnt_busy - snap_busy, 0);

        take_snap();
        send_line("GET", 0);
        send_byte(8'h4D, 0);
        idle(4);
        send_line("ODE", 0);
        idle(4);
        chk_delta("discard_busy", 0, 0, 0, 1, 0, 1);

        take_snap();
        send_str("RU", 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_hour", set_hour, 0);
        #1 rst = 1'b0;
        send_line("N", 1);
        idle(4);
        chk_delta("rst_mid_line", 0, 0, 0, 0, 0, 1);

        for (int n = 0; n < 300; n++) begin
            random_line();
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
            end
            idle($urandom_range(0, 3));
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
